// File: rtl/taskwait_merger_pkg.sv
// taskwait_merger_pkg: taskwait inStream field positions and merger state encoding
package taskwait_merger_pkg;

    localparam int TYPE_B                = 4;
    localparam int INSTREAM_COMPONENTS_L = 32;
    localparam int INSTREAM_COMPONENTS_H = 39;

    typedef logic [2:0] TwMergeState_t;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ACC_HDR  = 3'd1;
    localparam logic [2:0] ACC_PTID = 3'd2;
    localparam logic [2:0] FIN_HDR  = 3'd3;
    localparam logic [2:0] FIN_PTID = 3'd4;

    // Header synthesized for a child-finished notification: type 0, no components
    function automatic logic [63:0] fin_header();
        logic [63:0] h;
        h = '0;
        h[TYPE_B] = 1'b0;
        h[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = '0;
        return h;
    endfunction

endpackage

// File: rtl/taskwait_merger_out.sv
// tw_out_slot: one-beat registered output slice that drains and reloads without a bubble
module tw_out_slot #(
    parameter int ACC_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [63:0]         load_data,
    input  logic [ACC_BITS-1:0] load_tid,
    input  logic                load_last,
    input  logic                ready,
    output logic                slot_free,
    output logic [63:0]         data,
    output logic                valid,
    output logic [ACC_BITS-1:0] tid,
    output logic                last
);

    assign slot_free = !valid || ready;

    // Slot holds while stalled; otherwise takes the new beat or empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            tid   <= '0;
            last  <= 1'b0;
        end else if (slot_free) begin
            valid <= load;
            if (load) begin
                data <= load_data;
                tid  <= load_tid;
                last <= load_last;
            end
        end
    end

endmodule

// File: rtl/taskwait_merger.sv
// taskwait_merger: packet-atomic round-robin merge of accelerator taskwaits and finish notifications
module taskwait_merger
    import taskwait_merger_pkg::*;
#(
    parameter int ACC_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         accTw_TDATA,
    input  logic                accTw_TVALID,
    input  logic [ACC_BITS-1:0] accTw_TID,
    output logic                accTw_TREADY,
    input  logic [63:0]         fin_TDATA,
    input  logic                fin_TVALID,
    output logic                fin_TREADY,
    output logic [63:0]         outStream_TDATA,
    output logic                outStream_TVALID,
    output logic [ACC_BITS-1:0] outStream_TID,
    output logic                outStream_TLAST,
    input  logic                outStream_TREADY
);

    TwMergeState_t       state;
    logic                rr;
    logic [63:0]         fin_ptid;
    logic                slot_free;
    logic                in_acc;
    logic                acc_take;
    logic                fin_take;
    logic                load;
    logic [63:0]         load_data;
    logic [ACC_BITS-1:0] load_tid;
    logic                load_last;

    assign in_acc       = state == ACC_HDR || state == ACC_PTID;
    assign accTw_TREADY = in_acc && slot_free;
    assign fin_TREADY   = state == FIN_HDR && slot_free;
    assign acc_take     = accTw_TREADY && accTw_TVALID;
    assign fin_take     = fin_TREADY && fin_TVALID;

    // Beat presented to the output slot for the current state
    always_comb begin
        load      = acc_take || fin_take || (state == FIN_PTID && slot_free);
        load_data = state == FIN_HDR ? fin_header() : state == FIN_PTID ? fin_ptid : accTw_TDATA;
        load_tid  = in_acc ? accTw_TID : '0;
        load_last = state == ACC_PTID || state == FIN_PTID;
    end

    // Arbitration happens only in IDLE, so a granted packet runs to completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            fin_ptid <= '0;
        end else begin
            case (state)
                IDLE:     state <= accTw_TVALID && (!fin_TVALID || !rr) ? ACC_HDR :
                                   fin_TVALID ? FIN_HDR : IDLE;
                ACC_HDR:  if (acc_take) state <= ACC_PTID;
                ACC_PTID: if (acc_take) begin
                    state <= IDLE;
                    rr    <= 1'b1;
                end
                FIN_HDR:  if (fin_take) begin
                    state    <= FIN_PTID;
                    fin_ptid <= fin_TDATA;
                end
                FIN_PTID: if (slot_free) begin
                    state <= IDLE;
                    rr    <= 1'b0;
                end
                default:  state <= IDLE;
            endcase
        end
    end

    tw_out_slot #(.ACC_BITS(ACC_BITS)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_tid  (load_tid),
        .load_last (load_last),
        .ready     (outStream_TREADY),
        .slot_free (slot_free),
        .data      (outStream_TDATA),
        .valid     (outStream_TVALID),
        .tid       (outStream_TID),
        .last      (outStream_TLAST)
    );

endmodule

// File: tb/tb_taskwait_merger.sv
// tb_taskwait_merger: randomized scoreboard bench for the taskwait merger
module tb_taskwait_merger;
    import taskwait_merger_pkg::*;

    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   accTw_TDATA = '0;
    logic          accTw_TVALID = 1'b0;
    logic [AB-1:0] accTw_TID = '0;
    logic          accTw_TREADY;
    logic [63:0]   fin_TDATA = '0;
    logic          fin_TVALID = 1'b0;
    logic          fin_TREADY;
    logic [63:0]   outStream_TDATA;
    logic          outStream_TVALID;
    logic [AB-1:0] outStream_TID;
    logic          outStream_TLAST;
    logic          outStream_TREADY = 1'b1;

    always #5 clk = ~clk;

    taskwait_merger #(.ACC_BITS(AB)) dut (
        .clk              (clk),
        .rst              (rst),
        .accTw_TDATA      (accTw_TDATA),
        .accTw_TVALID     (accTw_TVALID),
        .accTw_TID        (accTw_TID),
        .accTw_TREADY     (accTw_TREADY),
        .fin_TDATA        (fin_TDATA),
        .fin_TVALID       (fin_TVALID),
        .fin_TREADY       (fin_TREADY),
        .outStream_TDATA  (outStream_TDATA),
        .outStream_TVALID (outStream_TVALID),
        .outStream_TID    (outStream_TID),
        .outStream_TLAST  (outStream_TLAST),
        .outStream_TREADY (outStream_TREADY)
    );

    typedef struct packed {logic [63:0] d; logic [AB-1:0] t; logic l;} beat_t;
    typedef struct packed {logic [AB-1:0] tid; logic [63:0] hdr; logic [63:0] ptid;} acc_pkt_t;

    acc_pkt_t    acc_q[$];
    logic [63:0] fin_q[$];
    beat_t       exp_q[$];
    int          order_q[$];
    int checks = 0, failures = 0;
    int acc_beat = 0, p_acc = 100, p_fin = 100;
    int out_beats = 0, fin_rdy_cycles = 0;
    bit rand_rdy = 0;
    bit acc_hs = 0, fin_hs = 0, out_hs = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Source drivers: hold a valid beat until it is taken, else maybe offer the next one
    task automatic drive();
        acc_pkt_t p;
        if (!(accTw_TVALID && !acc_hs)) begin
            if (acc_q.size() > 0 && $urandom_range(99) < p_acc) begin
                p = acc_q[0];
                accTw_TVALID = 1'b1;
                accTw_TID = p.tid;
                accTw_TDATA = acc_beat == 1 ? p.ptid : p.hdr;
            end else accTw_TVALID = 1'b0;
        end
        if (!(fin_TVALID && !fin_hs)) begin
            if (fin_q.size() > 0 && $urandom_range(99) < p_fin) begin
                fin_TVALID = 1'b1;
                fin_TDATA = fin_q[0];
            end else fin_TVALID = 1'b0;
        end
        if (rand_rdy) outStream_TREADY = $urandom_range(3) != 0;
    endtask

    // One clock: observe handshakes at negedge, score them, then advance the sources
    task automatic cycle();
        beat_t e;
        @(negedge clk);
        acc_hs = accTw_TVALID && accTw_TREADY;
        fin_hs = fin_TVALID && fin_TREADY;
        out_hs = outStream_TVALID && outStream_TREADY;
        chk("ready_excl", accTw_TREADY & fin_TREADY, 0);
        if (fin_TREADY) fin_rdy_cycles++;
        if (acc_hs) begin
            exp_q.push_back('{d: accTw_TDATA, t: accTw_TID, l: acc_beat == 1});
            if (acc_beat == 0) order_q.push_back(0);
        end
        if (fin_hs) begin
            exp_q.push_back('{d: 64'h0, t: '0, l: 1'b0});
            exp_q.push_back('{d: fin_TDATA, t: '0, l: 1'b1});
            order_q.push_back(1);
        end
        if (out_hs) begin
            out_beats++;
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", outStream_TDATA, e.d);
                chk("out_tid", outStream_TID, e.t);
                chk("out_last", outStream_TLAST, e.l);
            end
        end
        @(posedge clk);
        #1;
        if (acc_hs) begin
            if (acc_beat == 1) begin
                void'(acc_q.pop_front());
                acc_beat = 0;
            end else acc_beat = 1;
        end
        if (fin_hs) void'(fin_q.pop_front());
        drive();
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((acc_q.size() > 0 || fin_q.size() > 0 || exp_q.size() > 0 || outStream_TVALID) && n < 4000) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, n < 4000, 1);
    endtask

    task automatic wait_acc_hdr(string tag);
        int n = 0;
        while (acc_beat == 0 && n < 50) begin
            cycle();
            n++;
        end
        chk({tag, "_hdr_taken"}, acc_beat, 1);
    endtask

    task automatic push_acc();
        acc_q.push_back('{tid: AB'($urandom), hdr: {$urandom, $urandom}, ptid: {$urandom, $urandom}});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [63:0] hdr;
        int n;
        #12;
        chk("rst_valid", outStream_TVALID, 0);
        chk("rst_data", outStream_TDATA, 0);
        chk("rst_tid", outStream_TID, 0);
        chk("rst_last", outStream_TLAST, 0);
        chk("rst_acc_rdy", accTw_TREADY, 0);
        chk("rst_fin_rdy", fin_TREADY, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        hdr = (64'd1 << TYPE_B) | (64'd2 << INSTREAM_COMPONENTS_L);
        acc_q.push_back('{tid: 4'd3, hdr: hdr, ptid: 64'h5});
        out_beats = 0;
        fin_rdy_cycles = 0;
        drive();
        drain("acc_only");
        chk("acc_only_beats", out_beats, 2);
        chk("acc_only_fin_rdy", fin_rdy_cycles, 0);

        fin_q.push_back(64'h7);
        out_beats = 0;
        fin_rdy_cycles = 0;
        drive();
        drain("fin_only");
        chk("fin_only_beats", out_beats, 2);
        chk("fin_only_rdy_cycles", fin_rdy_cycles, 1);

        pulse_reset();
        order_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_acc();
            fin_q.push_back({$urandom, $urandom});
        end
        drive();
        drain("contention");
        chk("contention_pkts", order_q.size(), 8);
        for (int i = 0; i < order_q.size(); i++) chk("contention_order", order_q[i], i % 2);

        acc_q.push_back('{tid: 4'd9, hdr: hdr, ptid: 64'hABCD});
        out_beats = 0;
        drive();
        wait_acc_hdr("stall");
        outStream_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_acc_rdy", accTw_TREADY, 0);
            chk("stall_valid", outStream_TVALID, 1);
            chk("stall_data", outStream_TDATA, hdr);
            chk("stall_tid", outStream_TID, 9);
            chk("stall_last", outStream_TLAST, 0);
        end
        outStream_TREADY = 1'b1;
        drain("stall");
        chk("stall_beats", out_beats, 2);

        push_acc();
        drive();
        wait_acc_hdr("midrst");
        #2;
        chk("midrst_pre_valid", outStream_TVALID, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", outStream_TVALID, 0);
        exp_q.delete();
        acc_q.delete();
        acc_beat = 0;
        accTw_TVALID = 1'b0;
        acc_hs = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fin_q.push_back(64'h2A);
        out_beats = 0;
        drive();
        drain("midrst_fin");
        chk("midrst_fin_beats", out_beats, 2);

        for (int i = 0; i < 10; i++) fin_q.push_back({$urandom, $urandom});
        out_beats = 0;
        n = 0;
        drive();
        while (out_beats < 20 && n < 200) begin
            cycle();
            n++;
        end
        chk("thru_periods", n - 1, 30);
        drain("thru");

        rand_rdy = 1;
        p_acc = $urandom_range(30, 100);
        p_fin = $urandom_range(30, 100);
        for (int i = 0; i < 40; i++) begin
            push_acc();
            fin_q.push_back({$urandom, $urandom});
        end
        out_beats = 0;
        drive();
        drain("random");
        chk("random_beats", out_beats, 160);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
